// File: rtl/bus_arbiter.sv
// Two-port request arbiter in front of a single-outstanding memory port.
// Port 1 has fixed priority; a loss counter forces port 0 through after STARVE_LIMIT contests.
module bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_req_valid,
  output logic                s0_req_ready,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic                s0_wen,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic [DATA_W-1:0]   s0_wdata,
  output logic                s0_resp_valid,
  output logic [DATA_W-1:0]   s0_rdata,
  input  logic                s1_req_valid,
  output logic                s1_req_ready,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic                s1_wen,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic [DATA_W-1:0]   s1_wdata,
  output logic                s1_resp_valid,
  output logic [DATA_W-1:0]   s1_rdata,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic [ADDR_W-1:0]   m_addr,
  output logic                m_wen,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                owner,
  output logic                protocol_error
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             contested;
  logic             win;
  logic             accept;
  logic             resp_fire;

  assign contested = s0_req_valid & s1_req_valid;
  // win = 1 selects port 1
  assign win       = contested ? (starve_cnt < LIMIT) : s1_req_valid;
  // rst gating keeps the ready outputs at 0 while reset is held
  assign accept    = rst & (state == IDLE) & (s0_req_valid | s1_req_valid);
  assign resp_fire = (state == WAIT) & m_resp_valid;

  assign s0_req_ready  = accept & ~win;
  assign s1_req_ready  = accept & win;
  assign s0_resp_valid = resp_fire & ~owner;
  assign s1_resp_valid = resp_fire & owner;
  assign s0_rdata      = s0_resp_valid ? m_rdata : '0;
  assign s1_rdata      = s1_resp_valid ? m_rdata : '0;
  assign m_req_valid   = (state == ISSUE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= 1'b0;
      starve_cnt     <= '0;
      protocol_error <= 1'b0;
      m_addr         <= '0;
      m_wen          <= 1'b0;
      m_wstrb        <= '0;
      m_wdata        <= '0;
    end else begin
      // a response outside WAIT is dropped but remembered
      if (m_resp_valid && state != WAIT) protocol_error <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            m_addr  <= win ? s1_addr  : s0_addr;
            m_wen   <= win ? s1_wen   : s0_wen;
            m_wstrb <= win ? s1_wstrb : s0_wstrb;
            m_wdata <= win ? s1_wdata : s0_wdata;
            owner   <= win;
            state   <= ISSUE;
            if (!win) starve_cnt <= '0;
            else if (contested && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ISSUE:   if (m_req_ready) state <= WAIT;
        WAIT:    if (m_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: transaction-level model checked every cycle
// plus literal expectations for each scenario.
module tb_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_req_valid, s0_req_ready, s0_wen, s0_resp_valid;
  logic [AW-1:0] s0_addr;
  logic [SW-1:0] s0_wstrb;
  logic [DW-1:0] s0_wdata, s0_rdata;
  logic          s1_req_valid, s1_req_ready, s1_wen, s1_resp_valid;
  logic [AW-1:0] s1_addr;
  logic [SW-1:0] s1_wstrb;
  logic [DW-1:0] s1_wdata, s1_rdata;
  logic          m_req_valid, m_req_ready, m_wen, m_resp_valid;
  logic [AW-1:0] m_addr;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          busy, owner, protocol_error;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_addr(s0_addr),
    .s0_wen(s0_wen), .s0_wstrb(s0_wstrb), .s0_wdata(s0_wdata),
    .s0_resp_valid(s0_resp_valid), .s0_rdata(s0_rdata),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_addr(s1_addr),
    .s1_wen(s1_wen), .s1_wstrb(s1_wstrb), .s1_wdata(s1_wdata),
    .s1_resp_valid(s1_resp_valid), .s1_rdata(s1_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wen(m_wen), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_resp_valid(m_resp_valid), .m_rdata(m_rdata),
    .busy(busy), .owner(owner), .protocol_error(protocol_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one request in flight, split into "sent downstream" or not
  typedef struct packed {
    logic          port;
    logic [AW-1:0] addr;
    logic          wen;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
  } req_t;

  bit   md_busy = 0, md_issued = 0, md_perr = 0;
  int   md_losses = 0;
  req_t md_cur = '0;
  bit   grant_log[$];

  function automatic bit pick(input bit v0, input bit v1, input int losses);
    if (v0 && v1) return (losses >= LIM) ? 1'b0 : 1'b1;
    return v1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_busy = 0; md_issued = 0; md_perr = 0; md_losses = 0; md_cur = '0;
    end else begin
      bit p;
      if (m_resp_valid && !(md_busy && md_issued)) md_perr = 1;
      if (!md_busy) begin
        if (s0_req_valid || s1_req_valid) begin
          p = pick(s0_req_valid, s1_req_valid, md_losses);
          md_cur.port  = p;
          md_cur.addr  = p ? s1_addr  : s0_addr;
          md_cur.wen   = p ? s1_wen   : s0_wen;
          md_cur.wstrb = p ? s1_wstrb : s0_wstrb;
          md_cur.wdata = p ? s1_wdata : s0_wdata;
          if (!p) md_losses = 0;
          else if (s0_req_valid && md_losses < LIM) md_losses++;
          md_busy = 1; md_issued = 0;
          grant_log.push_back(p);
        end
      end else if (!md_issued) begin
        if (m_req_ready) md_issued = 1;
      end else if (m_resp_valid) begin
        md_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit any, p, resp;
    any  = rst && !md_busy && (s0_req_valid || s1_req_valid);
    p    = pick(s0_req_valid, s1_req_valid, md_losses);
    resp = md_busy && md_issued && m_resp_valid;
    check("s0_req_ready", s0_req_ready, any && !p);
    check("s1_req_ready", s1_req_ready, any && p);
    check("s0_resp_valid", s0_resp_valid, resp && !md_cur.port);
    check("s1_resp_valid", s1_resp_valid, resp && md_cur.port);
    check("s0_rdata", s0_rdata, (resp && !md_cur.port) ? m_rdata : '0);
    check("s1_rdata", s1_rdata, (resp && md_cur.port) ? m_rdata : '0);
    check("m_req_valid", m_req_valid, md_busy && !md_issued);
    check("m_addr", m_addr, md_cur.addr);
    check("m_wen", m_wen, md_cur.wen);
    check("m_wstrb", m_wstrb, md_cur.wstrb);
    check("m_wdata", m_wdata, md_cur.wdata);
    check("busy", busy, md_busy);
    check("owner", owner, md_cur.port);
    check("protocol_error", protocol_error, md_perr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full minimum-latency transaction starting at the current cycle
  task automatic txn(input bit v0, input bit v1, input logic [DW-1:0] rd, output bit g);
    s0_req_valid = v0; s1_req_valid = v1;
    @(negedge clk);
    check("accept_one_hot", s0_req_ready ^ s1_req_ready, 1);
    g = s1_req_ready;
    step();
    m_req_ready = 1;
    @(negedge clk);
    check("issue_valid", m_req_valid, 1);
    step();
    m_req_ready = 0; m_resp_valid = 1; m_rdata = rd;
    @(negedge clk);
    check("resp_valid", g ? s1_resp_valid : s0_resp_valid, 1);
    check("resp_rdata", g ? s1_rdata : s0_rdata, rd);
    step();
    m_resp_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit g;
    int base;
    bit exp_seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bit exp_starve[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    bit v0_starve[8]  = '{1, 1, 1, 0, 0, 0, 1, 1};

    rst = 0;
    s0_req_valid = 1; s0_addr = '0; s0_wen = 0; s0_wstrb = '0; s0_wdata = '0;
    s1_req_valid = 0; s1_addr = '0; s1_wen = 0; s1_wstrb = '0; s1_wdata = '0;
    m_req_ready = 0; m_resp_valid = 0; m_rdata = '0;
    @(negedge clk);
    check("reset_s0_ready", s0_req_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_perr", protocol_error, 0);
    step();
    s0_req_valid = 0;
    rst = 1;
    step();

    // basic s0 read
    s0_req_valid = 1; s0_addr = 32'h100;
    @(negedge clk);
    check("t1_s0_ready", s0_req_ready, 1);
    step();
    s0_req_valid = 0; m_req_ready = 1;
    @(negedge clk);
    check("t1_m_req_valid", m_req_valid, 1);
    check("t1_m_addr", m_addr, 32'h100);
    step();
    m_req_ready = 0; m_resp_valid = 1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_s0_resp", s0_resp_valid, 1);
    check("t1_s0_rdata", s0_rdata, 32'hDEADBEEF);
    check("t1_s1_resp", s1_resp_valid, 0);
    step();
    m_resp_valid = 0;

    // contested back-to-back grants
    s0_addr = 32'h1000; s1_addr = 32'h2000;
    base = grant_log.size();
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, 32'h5000 + i, g);
      check("t2_grant", g, exp_seq[i]);
      check("t2_model_grant", grant_log[base + i], exp_seq[i]);
    end
    s0_req_valid = 0; s1_req_valid = 0;
    step();

    // s1 write under 5 cycles of backpressure
    s1_req_valid = 1; s1_addr = 32'h200; s1_wen = 1; s1_wdata = 32'h12345678; s1_wstrb = 4'h3;
    @(negedge clk);
    check("t3_s1_ready", s1_req_ready, 1);
    step();
    s0_req_valid = 1; m_req_ready = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) m_req_ready = 1;
      @(negedge clk);
      check("t3_m_req_valid", m_req_valid, 1);
      check("t3_m_addr", m_addr, 32'h200);
      check("t3_m_wdata", m_wdata, 32'h12345678);
      check("t3_m_wstrb", m_wstrb, 4'h3);
      check("t3_m_wen", m_wen, 1);
      check("t3_busy", busy, 1);
      check("t3_no_accept", {s0_req_ready, s1_req_ready}, 2'b00);
      step();
    end
    m_req_ready = 0; s0_req_valid = 0; s1_req_valid = 0; s1_wen = 0; s1_wstrb = '0;
    m_resp_valid = 1; m_rdata = 32'h000000AA;
    @(negedge clk);
    check("t3_s1_resp", s1_resp_valid, 1);
    check("t3_s1_rdata", s1_rdata, 32'h000000AA);
    check("t3_s0_resp", s0_resp_valid, 0);
    step();
    m_resp_valid = 0;

    // stray response in IDLE
    m_resp_valid = 1;
    @(negedge clk);
    check("t4_perr_before", protocol_error, 0);
    check("t4_no_resp", {s0_resp_valid, s1_resp_valid}, 2'b00);
    step();
    m_resp_valid = 0;
    @(negedge clk);
    check("t4_perr_set", protocol_error, 1);
    check("t4_idle", busy, 0);
    step();
    s0_addr = 32'h300;
    txn(1, 0, 32'hCAFEF00D, g);
    check("t4_s0_grant", g, 0);
    s0_req_valid = 0;
    @(negedge clk);
    check("t4_perr_sticky", protocol_error, 1);
    step();

    // reset aborts a transaction in WAIT; stale response afterwards
    rst = 0;
    #1;
    check("t5_perr_cleared", protocol_error, 0);
    step();
    rst = 1;
    s1_req_valid = 1; s1_addr = 32'h400;
    @(negedge clk);
    check("t5_s1_ready", s1_req_ready, 1);
    step();
    s1_req_valid = 0; m_req_ready = 1;
    step();
    m_req_ready = 0;
    check("t5_busy_wait", busy, 1);
    #2 rst = 0;
    #1;
    check("t5_busy_reset", busy, 0);
    check("t5_mvalid_reset", m_req_valid, 0);
    check("t5_maddr_reset", m_addr, 0);
    check("t5_owner_reset", owner, 0);
    step();
    rst = 1; m_resp_valid = 1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    check("t5_stale_dropped", {s0_resp_valid, s1_resp_valid}, 2'b00);
    check("t5_idle", busy, 0);
    step();
    m_resp_valid = 0;
    @(negedge clk);
    check("t5_perr_set", protocol_error, 1);
    step();

    // uncontested s1 grants leave the loss count alone
    s0_addr = 32'h600; s1_addr = 32'h700;
    for (int i = 0; i < 8; i++) begin
      txn(v0_starve[i], 1, 32'h7000 + i, g);
      check("t6_grant", g, exp_starve[i]);
    end
    s0_req_valid = 0; s1_req_valid = 0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
